// File: rtl/axi_read_arbiter.sv
// Two-requester AXI read arbiter: one burst in flight, round-robin grant by default.
// Define AXI_ARB_DISPLAY_PRIORITY_EN to give requester 1 (display) fixed priority.
module axi_read_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] req_araddr  [0:1],
  input  logic [7:0]            req_arlen   [0:1],
  input  logic                  req_arvalid [0:1],
  output logic                  req_arready [0:1],
  output logic [DATA_WIDTH-1:0] req_rdata   [0:1],
  output logic                  req_rvalid  [0:1],
  input  logic                  req_rready  [0:1],
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic [7:0]            m_arlen,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  output logic                  m_rready,
  output logic                  protocol_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t                state, state_nxt;
  logic                  grant;
  logic                  sel;
  logic                  any_req;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            beat_cnt;

  assign any_req  = req_arvalid[0] | req_arvalid[1];
  assign m_araddr = addr_q;
  assign m_arlen  = len_q;

  // grant doubles as the last-granted requester for the round-robin tie break
  always_comb begin
`ifdef AXI_ARB_DISPLAY_PRIORITY_EN
    sel = req_arvalid[1];
`else
    if (req_arvalid[0] && req_arvalid[1])
      sel = ~grant;
    else
      sel = req_arvalid[1];
`endif
  end

  always_comb begin
    state_nxt   = state;
    req_arready = '{default: 1'b0};
    req_rvalid  = '{default: 1'b0};
    req_rdata   = '{default: '0};
    m_arvalid   = 1'b0;
    m_rready    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req && !reset) begin
          req_arready[sel] = 1'b1;
          state_nxt        = ADDR;
        end
      end
      ADDR: begin
        m_arvalid = 1'b1;
        if (m_arready)
          state_nxt = DATA;
      end
      DATA: begin
        req_rvalid[grant] = m_rvalid;
        req_rdata[grant]  = m_rdata;
        m_rready          = req_rready[grant];
        if (m_rvalid && req_rready[grant] && m_rlast)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= 1'b1;
      addr_q       <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (any_req) begin
            grant  <= sel;
            addr_q <= req_araddr[sel];
            len_q  <= req_arlen[sel];
          end
        end
        ADDR: begin
          if (m_arready)
            beat_cnt <= '0;
        end
        DATA: begin
          if (m_rvalid && m_rready) begin
            beat_cnt <= beat_cnt + 8'd1;
            // early rlast, or the final counted beat arriving without rlast
            if (m_rlast ? (beat_cnt != len_q) : (beat_cnt == len_q))
              protocol_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
